mem_port_arbiter: RTL

- Shares the single unified memory port between instruction fetch and the memory stage, which follows the execute stage.
- Arbitrates the two requesters and sequences each access through a fixed-latency RAM.
- Returns read data and write acknowledges to the requester that issued the access.
- Drives stall signals so the pipeline holds while its access is pending.

---
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency RAM port between instruction fetch and the memory stage.
// Define MEMARB_PERF_EN to add saturating stall-cycle counters.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 16,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic [1:0]        mem_op,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_data,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              stall_fetch,
    output logic              stall_mem,
    output logic              busy
`ifdef MEMARB_PERF_EN
    ,
    output logic [15:0]       fetch_stall_cnt,
    output logic [15:0]       mem_stall_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
    localparam logic [3:0] LAT = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] SL  = 4'(STARVE_LIMIT);
    state_t state, state_nx;
    logic [3:0] lat_cnt, starve_cnt;
    logic owner_mem, is_wr, mem_rq, grant_if, grant_mem, done;

    assign mem_rq      = (mem_op == 2'b01) || (mem_op == 2'b10);
    assign stall_fetch = if_req & ~if_valid;
    assign stall_mem   = mem_rq & ~mem_valid;

    // memory stage wins unless fetch has been passed over STARVE_LIMIT times
    always_comb begin
        grant_if  = (state == IDLE) && if_req && (!mem_rq || starve_cnt == SL);
        grant_mem = (state == IDLE) && mem_rq && !grant_if;
        done      = (state == WAIT) && (lat_cnt == 4'd0);
        state_nx  = state;
        case (state)
            IDLE:    state_nx = (grant_if || grant_mem) ? ACCESS : IDLE;
            ACCESS:  state_nx = WAIT;
            WAIT:    state_nx = done ? RESP : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            lat_cnt    <= '0;
            owner_mem  <= 1'b0;
            is_wr      <= 1'b0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            if_valid   <= 1'b0;
            if_data    <= '0;
            mem_valid  <= 1'b0;
            mem_rdata  <= '0;
            busy       <= 1'b0;
        end else begin
            state     <= state_nx;
            busy      <= state_nx != IDLE;
            ram_en    <= grant_if || grant_mem;
            ram_we    <= grant_mem && (mem_op == 2'b10);
            if_valid  <= done && !owner_mem;
            mem_valid <= done && owner_mem;
            if (state == ACCESS)
                lat_cnt <= LAT;
            else if (state == WAIT)
                lat_cnt <= lat_cnt - 4'd1;
            if (grant_if || grant_mem) begin
                owner_mem  <= grant_mem;
                is_wr      <= grant_mem && (mem_op == 2'b10);
                ram_addr   <= grant_mem ? mem_addr : if_addr;
                ram_wdata  <= mem_wdata;
                starve_cnt <= (grant_mem && if_req) ? ((starve_cnt == SL) ? SL : starve_cnt + 4'd1) : 4'd0;
            end
            if (done && owner_mem && !is_wr)
                mem_rdata <= ram_rdata;
            if (done && !owner_mem)
                if_data <= ram_rdata;
        end
    end

`ifdef MEMARB_PERF_EN
    always_ff @(posedge CLK) begin
        if (Reset) begin
            fetch_stall_cnt <= '0;
            mem_stall_cnt   <= '0;
        end else begin
            if (stall_fetch && fetch_stall_cnt != 16'hFFFF)
                fetch_stall_cnt <= fetch_stall_cnt + 16'd1;
            if (stall_mem && mem_stall_cnt != 16'hFFFF)
                mem_stall_cnt <= mem_stall_cnt + 16'd1;
        end
    end
`endif
endmodule
